// File: rtl/alu_pkg.sv
// Shared ALU op codes and controller state encoding; used by the share
// controller, the op decoder and the ALU itself.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_ILL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_illegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two ALU requesters and the share
// controller. Requester-side signals carry a 0/1 suffix per port.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;

    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention
// the one that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; one op in flight,
// operands held for an op-dependent count, result returned on a response handshake.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_rt_o,
    output logic [WIDTH-1:0] alu_rd_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    localparam int CNT_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] alu_rt_q;
    logic [WIDTH-1:0] alu_rd_q;
    logic [2:0]       alu_ctrl_q;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    logic [1:0]       gnt;
    logic [1:0]       req_ready_d;
    logic             accept;
    logic             sel;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_div0;
    logic [CNT_W-1:0] cnt_d;

    rr_arb2 u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    // Ready only ever reaches the granted requester, and only while idle.
    assign req_ready_d = (state_q == IDLE && rst_n) ? gnt : 2'b00;
    assign accept      = |(bus.req_valid & req_ready_d);
    assign sel         = req_ready_d[1];
    assign sel_op      = sel ? bus.req_op1 : bus.req_op0;
    assign sel_a       = sel ? bus.req_a1  : bus.req_a0;
    assign sel_b       = sel ? bus.req_b1  : bus.req_b0;
    assign sel_div0    = (sel_op == OP_DIV) && (sel_b == '0);

    always_comb begin
        cnt_d = CNT_W'(1);
        if (is_multi_cycle(sel_op)) begin
            cnt_d = (sel_op == OP_MUL) ? CNT_W'(MUL_CYC) : CNT_W'(DIV_CYC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_rt_q     <= '0;
            alu_rd_q     <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= sel;
                        owner_q      <= sel;
                        // Error ops answer straight away and leave the ALU inputs untouched.
                        if (is_illegal(sel_op)) begin
                            rsp_result_q <= '0;
                            rsp_zero_q   <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= {sel, ~sel};
                            state_q      <= RESP;
                        end else if (sel_div0) begin
                            rsp_result_q <= '1;
                            rsp_zero_q   <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= {sel, ~sel};
                            state_q      <= RESP;
                        end else begin
                            alu_rt_q   <= sel_a;
                            alu_rd_q   <= sel_b;
                            alu_ctrl_q <= sel_op;
                            cnt_q      <= cnt_d;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_result_q <= alu_result_i;
                        rsp_zero_q   <= alu_zero_i;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= {owner_q, ~owner_q};
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_d;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign alu_rt_o       = alu_rt_q;
    assign alu_rd_o       = alu_rd_q;
    assign alu_ctrl_o     = alu_ctrl_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scenario bench for alu_share_ctrl: a behavioural ALU, a scoreboard fed on
// accept and drained on response handshake, and one task per scenario.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W       = 16;
    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] alu_rt, alu_rd, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_zero, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t         sbq0[$];
    exp_t         sbq1[$];
    logic [W-1:0] lres[2];
    logic         lzero[2];
    logic         lerr[2];

    alu_share_ctrl_if #(.WIDTH(W)) bus();

    alu_share_ctrl #(.WIDTH(W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_rt_o     (alu_rt),
        .alu_rd_o     (alu_rd),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'd5:    r = a * b;
            3'd6:    r = (b == '0) ? '1 : a / b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res  = alu_f(op, a, b);
        e.zero = (e.res == '0);
        e.err  = 1'b0;
        if (op == 3'd7) begin
            e.res = '0; e.zero = 1'b1; e.err = 1'b1;
        end else if (op == 3'd6 && b == '0) begin
            e.res = '1; e.zero = 1'b0; e.err = 1'b1;
        end
        return e;
    endfunction

    always_comb begin
        alu_result = alu_f(alu_ctrl, alu_rt, alu_rd);
        alu_zero   = (alu_result == '0);
    end

    // Scoreboard: push on accept, pop and compare on response handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sbq0.delete();
            sbq1.delete();
        end else begin
            if (bus.req_valid[0] && bus.req_ready[0]) sbq0.push_back(model(bus.req_op0, bus.req_a0, bus.req_b0));
            if (bus.req_valid[1] && bus.req_ready[1]) sbq1.push_back(model(bus.req_op1, bus.req_a1, bus.req_b1));
            if (bus.rsp_valid != 2'b00) begin
                checks++;
                if (bus.rsp_valid !== 2'b01 && bus.rsp_valid !== 2'b10) begin
                    errors++;
                    $display("FAIL rsp_onehot got %b want one-hot", bus.rsp_valid);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (bus.rsp_valid[p] && bus.rsp_ready[p]) begin
                    exp_t e;
                    checks++;
                    if ((p == 0 && sbq0.size() == 0) || (p == 1 && sbq1.size() == 0)) begin
                        errors++;
                        $display("FAIL rsp_unexpected port %0d got %h want none", p, bus.rsp_result);
                    end else begin
                        e = (p == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {e.res, e.zero, e.err}) begin
                            errors++;
                            $display("FAIL rsp_data port %0d got res=%h z=%b e=%b want res=%h z=%b e=%b",
                                     p, bus.rsp_result, bus.rsp_zero, bus.rsp_err, e.res, e.zero, e.err);
                        end
                    end
                    lres[p]  = bus.rsp_result;
                    lzero[p] = bus.rsp_zero;
                    lerr[p]  = bus.rsp_err;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int p, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
        bus.req_valid[p] = 1'b1;
    endtask

    // Returns at posedge+1 after the accepting edge; acc = cycle of the accept.
    task automatic issue(input int p, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        @(posedge clk); #1;
        set_req(p, op, a, b);
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.req_ready[p]) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout port %0d got no ready want ready", p);
        end
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.rsp_valid[p]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout port %0d got no rsp_valid want rsp_valid", p);
        end
    endtask

    task automatic drain();
        int ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sbq0.size() == 0 && sbq1.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", sbq0.size(), sbq1.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int acc, seen;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        set_req(0, OP_ADD, 16'd1, 16'd1);
        set_req(1, OP_ADD, 16'd1, 16'd1);
        #12;
        checks++;
        if ({bus.req_ready, busy, bus.rsp_valid, bus.rsp_zero, bus.rsp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b rv=%b z=%b e=%b want all 0",
                     bus.req_ready, busy, bus.rsp_valid, bus.rsp_zero, bus.rsp_err);
        end
        checks++;
        if ({alu_rt, alu_rd, alu_ctrl, bus.rsp_result} !== '0) begin
            errors++;
            $display("FAIL reset_data got rt=%h rd=%h ctrl=%h res=%h want 0", alu_rt, alu_rd, alu_ctrl, bus.rsp_result);
        end
        bus.req_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;

        issue(0, OP_MUL, 16'd300, 16'd200, acc);
        #1;
        checks++;
        if (busy !== 1'b1 || alu_rt !== 16'd300 || alu_ctrl !== 3'd5) begin
            errors++;
            $display("FAIL mul_exec got busy=%b rt=%0d ctrl=%0d want 1/300/5", busy, alu_rt, alu_ctrl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.rsp_valid, bus.req_ready, alu_rt, alu_rd, alu_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b rv=%b rt=%h rd=%h ctrl=%h want 0", busy, bus.rsp_valid, alu_rt, alu_rd, alu_ctrl);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rsp_ready = 2'b11;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00 || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_rsp got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_contention();
        int order[3];
        int got = 0;
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, OP_SUB, 16'd7, 16'd7);
        set_req(1, OP_SLT, 16'd2, 16'd9);
        for (int n = 0; n < 60 && got < 3; n++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                order[got] = bus.req_ready[1] ? 1 : 0;
                got++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        checks++;
        if (got != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            errors++;
            $display("FAIL rr_order got n=%0d %0d,%0d,%0d want 3 0,1,0", got, order[0], order[1], order[2]);
        end
        drain();
        checks++;
        if (lres[0] !== 16'd0 || lzero[0] !== 1'b1 || lres[1] !== 16'd1 || lzero[1] !== 1'b0) begin
            errors++;
            $display("FAIL contention_res got r0=%h z0=%b r1=%h z1=%b want 0/1 1/0", lres[0], lzero[0], lres[1], lzero[1]);
        end
    endtask

    task automatic test_single_add();
        int acc, at;
        bus.rsp_ready = 2'b11;
        issue(0, OP_ADD, 16'h0005, 16'h0003, acc);
        @(negedge clk);
        checks++;
        if (alu_ctrl !== 3'd0 || alu_rt !== 16'h5 || alu_rd !== 16'h3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_exec got ctrl=%0d rt=%h rd=%h busy=%b want 0/5/3/1", alu_ctrl, alu_rt, alu_rd, busy);
        end
        wait_rsp(0, at);
        checks++;
        if (at != acc + 2 || bus.rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL add_latency got %0d rv=%b want %0d rv=01", at - acc, bus.rsp_valid, 2);
        end
        @(posedge clk); #1;
        checks++;
        if (lres[0] !== 16'd8 || lzero[0] !== 1'b0 || lerr[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_res got %h/%b/%b want 0008/0/0", lres[0], lzero[0], lerr[0]);
        end
    endtask

    task automatic test_div();
        int acc, at, bad = 0;
        bus.rsp_ready = 2'b11;
        issue(1, OP_DIV, 16'd100, 16'd7, acc);
        for (int i = 0; i < DIV_CYC; i++) begin
            @(negedge clk);
            if ({alu_rt, alu_rd, alu_ctrl} !== {16'd100, 16'd7, 3'd6} || bus.rsp_valid !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_hold got %0d bad cycles want 0", bad);
        end
        wait_rsp(1, at);
        checks++;
        if (at != acc + DIV_CYC + 1 || bus.rsp_valid !== 2'b10) begin
            errors++;
            $display("FAIL div_latency got %0d rv=%b want %0d rv=10", at - acc, bus.rsp_valid, DIV_CYC + 1);
        end
        @(posedge clk); #1;
        checks++;
        if (lres[1] !== 16'd14 || lerr[1] !== 1'b0) begin
            errors++;
            $display("FAIL div_res got %0d err=%b want 14 err=0", lres[1], lerr[1]);
        end
    endtask

    task automatic test_errors();
        int acc;
        bus.rsp_ready = 2'b11;
        issue(0, OP_DIV, 16'd55, 16'd0, acc);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b01 || {alu_rt, alu_rd, alu_ctrl} !== {16'd100, 16'd7, 3'd6}) begin
            errors++;
            $display("FAIL div0_skip got rv=%b rt=%0d rd=%0d ctrl=%0d want 01/100/7/6", bus.rsp_valid, alu_rt, alu_rd, alu_ctrl);
        end
        @(posedge clk); #1;
        checks++;
        if (lres[0] !== 16'hFFFF || lzero[0] !== 1'b0 || lerr[0] !== 1'b1) begin
            errors++;
            $display("FAIL div0_res got %h/%b/%b want FFFF/0/1", lres[0], lzero[0], lerr[0]);
        end
        issue(1, OP_ILL, 16'd1, 16'd2, acc);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b10 || {alu_rt, alu_rd, alu_ctrl} !== {16'd100, 16'd7, 3'd6}) begin
            errors++;
            $display("FAIL ill_skip got rv=%b rt=%0d rd=%0d ctrl=%0d want 10/100/7/6", bus.rsp_valid, alu_rt, alu_rd, alu_ctrl);
        end
        @(posedge clk); #1;
        checks++;
        if (lres[1] !== 16'h0000 || lzero[1] !== 1'b1 || lerr[1] !== 1'b1) begin
            errors++;
            $display("FAIL ill_res got %h/%b/%b want 0000/1/1", lres[1], lzero[1], lerr[1]);
        end
    endtask

    task automatic test_backpressure();
        int acc, at, bad = 0;
        bus.rsp_ready = 2'b10;  // only the non-owner is ready
        issue(0, OP_ADD, 16'd10, 16'd20, acc);
        @(posedge clk); #1;
        set_req(1, OP_OR, 16'h00F0, 16'h0F00);
        wait_rsp(0, at);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 16'd30 || bus.req_ready !== 2'b00 || !busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL bp_next_accept got rdy=%b rv=%b want 10/00", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready = 2'b11;
        drain();
        checks++;
        if (lres[0] !== 16'd30 || lres[1] !== 16'h0FF0) begin
            errors++;
            $display("FAIL bp_res got %h/%h want 001E/0FF0", lres[0], lres[1]);
        end
    endtask

    task automatic test_back_to_back();
        int a[2];
        int got = 0;
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, OP_AND, 16'hF0F0, 16'h0FF0);
        for (int n = 0; n < 40 && got < 2; n++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin
                a[got] = cyc;
                got++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        checks++;
        if (got != 2 || a[1] - a[0] != 3) begin
            errors++;
            $display("FAIL b2b_period got n=%0d period=%0d want 2/3", got, a[1] - a[0]);
        end
        drain();
        checks++;
        if (lres[0] !== 16'h00F0 || lzero[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_res got %h/%b want 00F0/0", lres[0], lzero[0]);
        end
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0;
        bus.req_b0 = '0; bus.req_b1 = '0;
        test_reset();
        test_contention();
        test_single_add();
        test_div();
        test_errors();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
